// File: rtl/fan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fan_ctrl_pkg
// Shared types and constants for the fan ramp scheduler slice.
//   fan_speed_t  : 2-bit applied/target speed (legal values 1..3)
//   fan_state_t  : sequencer states (IDLE, DWELL)
//   TEMP_LO/HI   : automatic speed thresholds in degrees
//   RPM_PER_STEP : rpm contributed by each speed step
//   speed_to_rpm : maps a speed code to its rpm value
// -----------------------------------------------------------------------------
package fan_ctrl_pkg;

  typedef logic [1:0] fan_speed_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DWELL = 1'b1
  } fan_state_t;

  localparam logic [7:0]  TEMP_LO      = 8'd23;
  localparam logic [7:0]  TEMP_HI      = 8'd27;
  localparam logic [11:0] RPM_PER_STEP = 12'd1000;

  // Any code outside 2..3 (including the illegal 0) reads as the slowest speed,
  // so the rpm output can never show anything but 1000/2000/3000.
  function automatic logic [11:0] speed_to_rpm(input fan_speed_t speed);
    logic [11:0] rpm;
    case (speed)
      2'd2:    rpm = RPM_PER_STEP * 12'd2;
      2'd3:    rpm = RPM_PER_STEP * 12'd3;
      default: rpm = RPM_PER_STEP;
    endcase
    return rpm;
  endfunction

endpackage

// File: rtl/fan_target_sel.sv
// -----------------------------------------------------------------------------
// fan_target_sel
// Combinational target-speed selection.
//   HYST           : step-down hysteresis in degrees (active only when the
//                    FAN_HYSTERESIS_EN macro is defined)
//   temp_q         : in  8  latched temperature
//   cur_speed      : in  2  currently applied speed (needed for hysteresis)
//   override_en    : in  1  manual override request
//   override_speed : in  2  manual speed, 0 treated as 1
//   target         : out 2  selected target speed, always 1..3
// Optional feature macro: FAN_HYSTERESIS_EN
// -----------------------------------------------------------------------------
module fan_target_sel
  import fan_ctrl_pkg::*;
#(
  parameter int HYST = 2
) (
  input  logic [7:0] temp_q,
  input  logic [1:0] cur_speed,
  input  logic       override_en,
  input  logic [1:0] override_speed,
  output logic [1:0] target
);

`ifdef FAN_HYSTERESIS_EN
  localparam int HYST_EFF = HYST;
`else
  // A zero offset makes the step-down thresholds collapse onto the step-up
  // ones, so the same selection logic serves both builds.
  localparam int HYST_EFF = HYST * 0;
`endif

  localparam int LO_DN_I = int'(TEMP_LO) - HYST_EFF;
  localparam int HI_DN_I = int'(TEMP_HI) - HYST_EFF;
  // A hysteresis larger than the threshold clamps at 0: that step-down never fires.
  localparam logic [7:0] LO_DN = (LO_DN_I < 0) ? 8'd0 : 8'(LO_DN_I);
  localparam logic [7:0] HI_DN = (HI_DN_I < 0) ? 8'd0 : 8'(HI_DN_I);

  fan_speed_t auto_s;

  // Automatic target: rising thresholds are fixed, falling thresholds depend on
  // the speed we are currently at.
  always_comb begin
    auto_s = 2'd1;
    case (cur_speed)
      2'd3: begin
        if (temp_q < LO_DN) begin
          auto_s = 2'd1;
        end else if (temp_q < HI_DN) begin
          auto_s = 2'd2;
        end else begin
          auto_s = 2'd3;
        end
      end
      2'd2: begin
        if (temp_q >= TEMP_HI) begin
          auto_s = 2'd3;
        end else if (temp_q < LO_DN) begin
          auto_s = 2'd1;
        end else begin
          auto_s = 2'd2;
        end
      end
      default: begin
        if (temp_q >= TEMP_HI) begin
          auto_s = 2'd3;
        end else if (temp_q >= TEMP_LO) begin
          auto_s = 2'd2;
        end else begin
          auto_s = 2'd1;
        end
      end
    endcase
  end

  // Override wins outright and bypasses hysteresis.
  always_comb begin
    target = auto_s;
    if (override_en) begin
      if (override_speed == 2'd0) begin
        target = 2'd1;
      end else begin
        target = override_speed;
      end
    end else begin
      target = auto_s;
    end
  end

endmodule

// File: rtl/fan_ramp_scheduler.sv
// -----------------------------------------------------------------------------
// fan_ramp_scheduler
// Steps the fan speed one level at a time toward a temperature- or
// override-derived target, holding each step for a minimum dwell.
//   DWELL_CYCLES      : clocks spent in DWELL after each step (1..65535)
//   HYST              : step-down hysteresis (FAN_HYSTERESIS_EN builds only)
//   clk               : in  1  clock, rising edge
//   rst               : in  1  synchronous active-high reset
//   temp_valid        : in  1  temperature sample strobe
//   temperature_input : in  8  unsigned temperature in degrees
//   override_en       : in  1  manual override (level)
//   override_speed    : in  2  manual speed, 0 treated as 1
//   fan_speed         : out 2  applied speed 1..3 (registered)
//   fan_rpm           : out 12 applied speed x 1000 (registered)
//   busy              : out 1  high while in DWELL (registered)
// Optional feature macro: FAN_HYSTERESIS_EN
// -----------------------------------------------------------------------------
module fan_ramp_scheduler
  import fan_ctrl_pkg::*;
#(
  parameter int DWELL_CYCLES = 1000,
  parameter int HYST         = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        temp_valid,
  input  logic [7:0]  temperature_input,
  input  logic        override_en,
  input  logic [1:0]  override_speed,
  output logic [1:0]  fan_speed,
  output logic [11:0] fan_rpm,
  output logic        busy
);

  // Counter reloads with DWELL_CYCLES-1; the extra IDLE edge after it hits
  // zero gives DWELL_CYCLES+1 edges between steps.
  localparam logic [15:0] DWELL_LOAD = 16'(DWELL_CYCLES - 1);

  fan_state_t  state_r, state_next_s;
  logic [15:0] cnt_r, cnt_next_s;
  fan_speed_t  speed_r, speed_next_s;
  logic [11:0] rpm_r, rpm_next_s;
  logic        busy_r, busy_next_s;
  logic [7:0]  temp_q_r;
  fan_speed_t  target_s;
  logic        step_s;

  fan_target_sel #(
    .HYST (HYST)
  ) u_target_sel (
    .temp_q         (temp_q_r),
    .cur_speed      (speed_r),
    .override_en    (override_en),
    .override_speed (override_speed),
    .target         (target_s)
  );

  // State, dwell counter, outputs and the temperature latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 16'd0;
      speed_r  <= 2'd1;
      rpm_r    <= RPM_PER_STEP;
      busy_r   <= 1'b0;
      temp_q_r <= 8'd0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      speed_r <= speed_next_s;
      rpm_r   <= rpm_next_s;
      busy_r  <= busy_next_s;
      if (temp_valid) begin
        temp_q_r <= temperature_input;
      end
    end
  end

  // Next-state and dwell counter: step from IDLE, count down in DWELL.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    step_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (target_s != speed_r) begin
          step_s       = 1'b1;
          state_next_s = ST_DWELL;
          cnt_next_s   = DWELL_LOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_DWELL: begin
        if (cnt_r == 16'd0) begin
          state_next_s = ST_IDLE;
        end else begin
          cnt_next_s = cnt_r - 16'd1;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = 16'd0;
      end
    endcase
  end

  // Output values for the next edge: a single +/-1 step toward the target.
  always_comb begin
    speed_next_s = speed_r;
    if (step_s) begin
      if (target_s > speed_r) begin
        speed_next_s = speed_r + 2'd1;
      end else begin
        speed_next_s = speed_r - 2'd1;
      end
    end else begin
      speed_next_s = speed_r;
    end
    rpm_next_s  = speed_to_rpm(speed_next_s);
    busy_next_s = (state_next_s == ST_DWELL);
  end

  assign fan_speed = speed_r;
  assign fan_rpm   = rpm_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_fan_ramp_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fan_ramp_scheduler
// Two instances share the stimulus: u_dut_a (DWELL_CYCLES=4) and u_dut_b
// (DWELL_CYCLES=1). A behavioural model predicts every cycle's outputs; the
// predictions are queued at drive time and compared after the edge. Directed
// checks cover the ramp timing, reversal, override, hysteresis and reset.
// -----------------------------------------------------------------------------
module tb_fan_ramp_scheduler;

  localparam int DW_A  = 4;
  localparam int DW_B  = 1;
  localparam int HYST  = 2;
  localparam int BIG   = 1000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        temp_valid = 1'b0;
  logic [7:0]  temperature_input = 8'd0;
  logic        override_en = 1'b0;
  logic [1:0]  override_speed = 2'd0;
  logic [1:0]  spd_a, spd_b;
  logic [11:0] rpm_a, rpm_b;
  logic        busy_a, busy_b;

  always #5 clk = ~clk;

  fan_ramp_scheduler #(.DWELL_CYCLES(DW_A), .HYST(HYST)) u_dut_a (
    .clk(clk), .rst(rst), .temp_valid(temp_valid),
    .temperature_input(temperature_input), .override_en(override_en),
    .override_speed(override_speed), .fan_speed(spd_a), .fan_rpm(rpm_a),
    .busy(busy_a));

  fan_ramp_scheduler #(.DWELL_CYCLES(DW_B), .HYST(HYST)) u_dut_b (
    .clk(clk), .rst(rst), .temp_valid(temp_valid),
    .temperature_input(temperature_input), .override_en(override_en),
    .override_speed(override_speed), .fan_speed(spd_b), .fan_rpm(rpm_b),
    .busy(busy_b));

  int n_checks = 0;
  int n_errors = 0;

  typedef struct { int spd; int rpm; int busy; } exp_t;
  exp_t q_a[$];
  exp_t q_b[$];

  int m_speed[2] = '{1, 1};
  int m_since[2] = '{BIG, BIG};
  int m_dwell[2] = '{DW_A, DW_B};
  int m_temp     = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Automatic target: step-up thresholds 23/27, step-down thresholds lowered
  // by HYST only in hysteresis builds.
  function automatic int auto_tgt(input int t, input int cur);
    int raw, lo_dn, hi_dn;
`ifdef FAN_HYSTERESIS_EN
    lo_dn = 23 - HYST;
    hi_dn = 27 - HYST;
`else
    lo_dn = 23;
    hi_dn = 27;
`endif
    raw = (t < 23) ? 1 : ((t < 27) ? 2 : 3);
    if (raw < cur) begin
      if (cur == 3) return (t < lo_dn) ? 1 : ((t < hi_dn) ? 2 : 3);
      if (cur == 2) return (t < lo_dn) ? 1 : 2;
    end
    return raw;
  endfunction

  // Predict the edge from the currently driven inputs, queue it, then let the
  // edge happen and compare both instances against their queued prediction.
  task automatic cycle();
    exp_t e, got;
    int tgt;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_speed[i] = 1;
        m_since[i] = BIG;
      end else begin
        if (override_en) tgt = (override_speed == 2'd0) ? 1 : int'(override_speed);
        else             tgt = auto_tgt(m_temp, m_speed[i]);
        if (m_since[i] >= m_dwell[i] && tgt != m_speed[i]) begin
          m_speed[i] = m_speed[i] + ((tgt > m_speed[i]) ? 1 : -1);
          m_since[i] = 0;
        end else if (m_since[i] < BIG) begin
          m_since[i] = m_since[i] + 1;
        end
      end
      e.spd  = m_speed[i];
      e.rpm  = m_speed[i] * 1000;
      e.busy = (m_since[i] < m_dwell[i]) ? 1 : 0;
      if (i == 0) q_a.push_back(e);
      else        q_b.push_back(e);
    end
    if (rst)             m_temp = 0;
    else if (temp_valid) m_temp = int'(temperature_input);

    @(posedge clk);
    #1;
    got = q_a.pop_front();
    check_val("a_speed", spd_a, got.spd);
    check_val("a_rpm", rpm_a, got.rpm);
    check_val("a_busy", busy_a, got.busy);
    got = q_b.pop_front();
    check_val("b_speed", spd_b, got.spd);
    check_val("b_rpm", rpm_b, got.rpm);
    check_val("b_busy", busy_b, got.busy);
  endtask

  task automatic drive(input logic r, input logic tv, input logic [7:0] t,
                       input logic ove, input logic [1:0] ovs);
    rst = r;
    temp_valid = tv;
    temperature_input = t;
    override_en = ove;
    override_speed = ovs;
    cycle();
    temp_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    int max_spd;

    // Reset
    drive(1'b1, 1'b0, 8'd0, 1'b0, 2'd0);
    drive(1'b1, 1'b0, 8'd0, 1'b0, 2'd0);
    check_val("rst_speed", spd_a, 1);
    check_val("rst_rpm", rpm_a, 1000);
    check_val("rst_busy", busy_a, 0);

    // Ramp up: sample 30, step to 2 next edge, 3 five edges later
    drive(1'b0, 1'b1, 8'd30, 1'b0, 2'd0);
    check_val("ramp_sample_edge", spd_a, 1);
    idle(1);
    check_val("ramp_first_step", spd_a, 2);
    check_val("ramp_busy_on", busy_a, 1);
    idle(3);
    check_val("ramp_busy_4th", busy_a, 1);
    idle(1);
    check_val("ramp_gap_speed", spd_a, 2);
    check_val("ramp_gap_busy", busy_a, 0);
    idle(1);
    check_val("ramp_second_step", spd_a, 3);
    check_val("ramp_rpm_3", rpm_a, 3000);

    // Reset mid-dwell at speed 3, with sample and override also asserted
    idle(2);
    check_val("pre_rst_busy", busy_a, 1);
    drive(1'b1, 1'b1, 8'd40, 1'b1, 2'd3);
    check_val("rst_mid_speed", spd_a, 1);
    check_val("rst_mid_rpm", rpm_a, 1000);
    check_val("rst_mid_busy", busy_a, 0);

    // Reversal mid-dwell at speed 2
    drive(1'b0, 1'b1, 8'd25, 1'b0, 2'd0);
    idle(1);
    check_val("rev_at_2", spd_a, 2);
    drive(1'b0, 1'b1, 8'd30, 1'b0, 2'd0);
    drive(1'b0, 1'b1, 8'd10, 1'b0, 2'd0);
    max_spd = 0;
    for (int k = 0; k < 12; k++) begin
      idle(1);
      if (int'(spd_a) > max_spd) max_spd = int'(spd_a);
    end
    check_val("rev_never_3", max_spd, 2);
    check_val("rev_final", spd_a, 1);

    // Override 0 -> treated as 1, then release back to automatic 3
    drive(1'b0, 1'b1, 8'd30, 1'b0, 2'd0);
    idle(12);
    check_val("ovr_auto_3", spd_a, 3);
    override_en = 1'b1;
    override_speed = 2'd0;
    idle(1);
    check_val("ovr_first_down", spd_a, 2);
    idle(13);
    check_val("ovr_hold_1", spd_a, 1);
    override_en = 1'b0;
    idle(14);
    check_val("ovr_release_3", spd_a, 3);

    // Hysteresis
    drive(1'b0, 1'b1, 8'd26, 1'b0, 2'd0);
    idle(8);
`ifdef FAN_HYSTERESIS_EN
    check_val("hyst_26", spd_a, 3);
`else
    check_val("hyst_26", spd_a, 2);
`endif
    drive(1'b0, 1'b1, 8'd30, 1'b0, 2'd0);
    idle(12);
    drive(1'b0, 1'b1, 8'd25, 1'b0, 2'd0);
    idle(8);
`ifdef FAN_HYSTERESIS_EN
    check_val("hyst_25", spd_a, 3);
`else
    check_val("hyst_25", spd_a, 2);
`endif
    drive(1'b0, 1'b1, 8'd30, 1'b0, 2'd0);
    idle(12);
    drive(1'b0, 1'b1, 8'd24, 1'b0, 2'd0);
    idle(8);
    check_val("hyst_24", spd_a, 2);

    // DWELL_CYCLES=1 with temperature 255: steps two edges apart
    drive(1'b1, 1'b0, 8'd0, 1'b0, 2'd0);
    drive(1'b0, 1'b1, 8'd255, 1'b0, 2'd0);
    idle(1);
    check_val("dw1_first", spd_b, 2);
    idle(1);
    check_val("dw1_between", spd_b, 2);
    idle(1);
    check_val("dw1_second", spd_b, 3);

    // Random traffic, checked cycle by cycle against the model
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 59) == 0);
      temp_valid = ($urandom_range(0, 3) == 0);
      temperature_input = 8'($urandom_range(0, 40));
      if ($urandom_range(0, 15) == 0) temperature_input = 8'd255;
      if ($urandom_range(0, 19) == 0) override_en = ~override_en;
      override_speed = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
